// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants, the channel-width helper and the
// divider configuration record used by the multi-channel clock divider.
//   CNT_W_DEFAULT : default counter/divisor/high-time width
//   DIV_MIN       : smallest legal divisor; smaller loads are rejected
//   div_cfg_t     : {div, high} pair at the default width
//   ch_width()    : channel-index width, at least 1 bit
package clk_div_pkg;

  localparam int CNT_W_DEFAULT = 16;
  localparam int DIV_MIN       = 2;

  typedef struct packed {
    logic [CNT_W_DEFAULT-1:0] div;
    logic [CNT_W_DEFAULT-1:0] high;
  } div_cfg_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one programmable divider channel.
// Holds the period counter, the active {div, high} pair, a shadow pair
// for a pending reprogram, and the registered outputs.
//   clk, rst        : clock, asynchronous active-high reset
//   en, restart     : count enable, phase-align pulse (restart wins)
//   load            : capture load_div/load_high into the shadow pair
//   small_clk, tick : divided clock and period-start strobe (registered)
//   applied         : pulse when the shadow pair becomes active
//   pending         : shadow pair waiting for a period boundary
module clk_div_channel #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  input  logic [CNT_W-1:0] load_high,
  output logic             small_clk,
  output logic             tick,
  output logic             applied,
  output logic             pending
);

  typedef struct packed {
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] high;
  } cfg_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam cfg_t RESET_CFG = '{div: CNT_W'(DEFAULT_DIV), high: CNT_W'(DEFAULT_DIV / 2)};

  cfg_t             active_reg, active_next;
  cfg_t             shadow_reg, shadow_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc, high_eff;
  logic             pending_reg, pending_next;
  logic             small_clk_reg, small_clk_next;
  logic             tick_reg, tick_next;
  logic             applied_reg, applied_next;
  logic             wrap, apply;

  always_comb begin
    wrap    = (cnt_reg == active_reg.div - ONE);
    cnt_inc = wrap ? '0 : cnt_reg + ONE;
    // A pending pair takes over at a restart or at an enabled wrap.
    apply    = pending_reg & (restart | (en & wrap));
    // The edge that applies a new pair already shapes small_clk with it.
    high_eff = apply ? shadow_reg.high : active_reg.high;

    active_next    = active_reg;
    shadow_next    = shadow_reg;
    cnt_next       = cnt_reg;
    pending_next   = pending_reg;
    small_clk_next = small_clk_reg;
    tick_next      = 1'b0;
    applied_next   = 1'b0;

    if (restart) begin
      cnt_next       = '0;
      tick_next      = 1'b1;
      small_clk_next = ('0 < high_eff);
    end else if (en) begin
      cnt_next       = cnt_inc;
      tick_next      = (cnt_inc == '0);
      small_clk_next = (cnt_inc < high_eff);
    end

    if (apply) begin
      active_next  = shadow_reg;
      pending_next = 1'b0;
      applied_next = 1'b1;
    end

    // Loads are only offered while nothing is pending, so this never
    // collides with an apply; a fresh load always waits for the next
    // boundary (or restart) after this edge.
    if (load) begin
      shadow_next  = '{div: load_div, high: load_high};
      pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_reg    <= RESET_CFG;
      shadow_reg    <= RESET_CFG;
      cnt_reg       <= CNT_W'(DEFAULT_DIV - 1);
      pending_reg   <= 1'b0;
      small_clk_reg <= 1'b0;
      tick_reg      <= 1'b0;
      applied_reg   <= 1'b0;
    end else begin
      active_reg    <= active_next;
      shadow_reg    <= shadow_next;
      cnt_reg       <= cnt_next;
      pending_reg   <= pending_next;
      small_clk_reg <= small_clk_next;
      tick_reg      <= tick_next;
      applied_reg   <= applied_next;
    end
  end

  assign small_clk = small_clk_reg;
  assign tick      = tick_reg;
  assign applied   = applied_reg;
  assign pending   = pending_reg;

endmodule

// File: rtl/multi_clk_divider.sv
// multi_clk_divider: bank of NUM_CH independent programmable dividers.
//   bigClk, rst      : clock, asynchronous active-high reset
//   en, restart      : global count enable, global phase-align pulse
//   loadValid/Ready  : load handshake; loadCh selects the channel,
//                      loadDiv/loadHigh give the new period and high-time
//   loadErr          : pulse after an accepted load with loadDiv < 2
//   smallClk, tick   : per-channel divided clock and period strobe
//   applied          : per-channel pulse when a pending load takes effect
module multi_clk_divider
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DEFAULT_DIV = 6,
  parameter int CH_W        = ch_width(NUM_CH)
) (
  input  logic              bigClk,
  input  logic              rst,
  input  logic              en,
  input  logic              restart,
  input  logic              loadValid,
  output logic              loadReady,
  input  logic [CH_W-1:0]   loadCh,
  input  logic [CNT_W-1:0]  loadDiv,
  input  logic [CNT_W-1:0]  loadHigh,
  output logic              loadErr,
  output logic [NUM_CH-1:0] smallClk,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] applied
);

  localparam int CH_SPAN = 1 << CH_W;

  logic [NUM_CH-1:0]  pending;
  logic [CH_SPAN-1:0] pending_pad;
  logic               in_range, accept, div_ok;
  logic               load_err_reg;

  // Pad pending to the full index space so any loadCh value indexes safely;
  // out-of-range slots are masked by in_range anyway.
  always_comb begin
    pending_pad             = '0;
    pending_pad[NUM_CH-1:0] = pending;
  end

  assign in_range  = ({1'b0, loadCh} < (CH_W + 1)'(NUM_CH));
  assign loadReady = in_range & ~pending_pad[loadCh];
  assign accept    = loadValid & loadReady;
  assign div_ok    = (loadDiv >= CNT_W'(DIV_MIN));

  always_ff @(posedge bigClk or posedge rst) begin
    if (rst) begin
      load_err_reg <= 1'b0;
    end else begin
      load_err_reg <= accept & ~div_ok;
    end
  end

  assign loadErr = load_err_reg;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      clk_div_channel #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
        .clk       (bigClk),
        .rst       (rst),
        .en        (en),
        .restart   (restart),
        .load      (accept & div_ok & (loadCh == CH_W'(gi))),
        .load_div  (loadDiv),
        .load_high (loadHigh),
        .small_clk (smallClk[gi]),
        .tick      (tick[gi]),
        .applied   (applied[gi]),
        .pending   (pending[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_clk_divider.sv
module tb_multi_clk_divider;

  logic        bigClk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        restart = 1'b0;
  logic        loadValid = 1'b0;
  logic        loadReady;
  logic [1:0]  loadCh = 2'd0;
  logic [15:0] loadDiv = 16'd0;
  logic [15:0] loadHigh = 16'd0;
  logic        loadErr;
  logic [2:0]  smallClk, tick, applied;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;

  // Behavioural reference: per-channel period position, active and shadow settings.
  int mdiv[3], mhigh[3], mcnt[3], sdiv[3], shigh[3];
  bit mpend[3];
  bit msc[3];

  multi_clk_divider #(.NUM_CH(3), .CNT_W(16), .DEFAULT_DIV(6)) dut (
    .bigClk(bigClk), .rst(rst), .en(en), .restart(restart),
    .loadValid(loadValid), .loadReady(loadReady), .loadCh(loadCh),
    .loadDiv(loadDiv), .loadHigh(loadHigh), .loadErr(loadErr),
    .smallClk(smallClk), .tick(tick), .applied(applied)
  );

  always #5 bigClk = ~bigClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, edge_no, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      mdiv[c] = 6; mhigh[c] = 3; mcnt[c] = 5;
      sdiv[c] = 6; shigh[c] = 3; mpend[c] = 0; msc[c] = 0;
    end
  endtask

  // One bigClk edge: predict, clock, then compare all registered outputs.
  task automatic step();
    logic [2:0] esc, etk, eap;
    bit acc, eerr;
    acc = 0;
    if (loadCh < 2'd3) acc = loadValid && !mpend[loadCh];
    for (int c = 0; c < 3; c++) begin
      eap[c] = 1'b0;
      etk[c] = 1'b0;
      if (restart) begin
        if (mpend[c]) begin
          mdiv[c] = sdiv[c]; mhigh[c] = shigh[c]; mpend[c] = 0; eap[c] = 1'b1;
        end
        mcnt[c] = 0;
        etk[c]  = 1'b1;
        msc[c]  = (0 < mhigh[c]);
      end else if (en) begin
        mcnt[c] = (mcnt[c] == mdiv[c] - 1) ? 0 : mcnt[c] + 1;
        if (mcnt[c] == 0 && mpend[c]) begin
          mdiv[c] = sdiv[c]; mhigh[c] = shigh[c]; mpend[c] = 0; eap[c] = 1'b1;
        end
        etk[c] = (mcnt[c] == 0);
        msc[c] = (mcnt[c] < mhigh[c]);
      end
      esc[c] = msc[c];
    end
    if (acc && loadDiv >= 16'd2) begin
      sdiv[loadCh] = int'(loadDiv); shigh[loadCh] = int'(loadHigh); mpend[loadCh] = 1;
    end
    eerr = acc && (loadDiv < 16'd2);
    @(posedge bigClk);
    #1;
    edge_no++;
    $display("edge %0d en=%0b restart=%0b load=%0b ch=%0d smallClk=%b tick=%b applied=%b loadErr=%0b",
             edge_no, en, restart, loadValid, loadCh, smallClk, tick, applied, loadErr);
    chk("smallClk", 32'(smallClk), 32'(esc));
    chk("tick", 32'(tick), 32'(etk));
    chk("applied", 32'(applied), 32'(eap));
    chk("loadErr", 32'(loadErr), 32'(eerr));
  endtask

  initial begin
    model_reset();
    // Reset state
    @(posedge bigClk); @(posedge bigClk); #1;
    chk("rst_smallClk", 32'(smallClk), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_applied", 32'(applied), 32'd0);
    chk("rst_loadErr", 32'(loadErr), 32'd0);
    chk("rst_loadReady", 32'(loadReady), 32'd1);
    rst = 1'b0;
    en  = 1'b1;

    // Defaults: first edge wraps to period start
    step();
    chk("first_tick", 32'(tick), 32'd7);
    chk("first_smallClk", 32'(smallClk), 32'd7);
    for (int i = 0; i < 13; i++) step();

    // Load ch1 div=4 high=1 mid-period
    loadValid = 1'b1; loadCh = 2'd1; loadDiv = 16'd4; loadHigh = 16'd1;
    #1 chk("ready_before_load", 32'(loadReady), 32'd1);
    step();
    loadValid = 1'b0;
    #1 chk("ready_while_pending", 32'(loadReady), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ready_still_pending", 32'(loadReady), 32'd0);
    end
    step();
    chk("applied_ch1", 32'(applied), 32'd2);
    chk("ready_after_apply", 32'(loadReady), 32'd1);
    for (int i = 0; i < 8; i++) step();

    // Rejected divisor
    loadValid = 1'b1; loadCh = 2'd0; loadDiv = 16'd1; loadHigh = 16'd0;
    step();
    chk("loadErr_pulse", 32'(loadErr), 32'd1);
    loadValid = 1'b0;
    step();
    chk("loadErr_clear", 32'(loadErr), 32'd0);

    // Out-of-range channel is never accepted
    loadValid = 1'b1; loadCh = 2'd3; loadDiv = 16'd1;
    #1 chk("ready_out_of_range", 32'(loadReady), 32'd0);
    step();
    loadValid = 1'b0; loadCh = 2'd0;

    // Enable low for 5 cycles, then resume
    step();
    en = 1'b0;
    for (int i = 0; i < 5; i++) step();
    en = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Program ch0 div=5 high=2, ch1 div=7 high=3, then restart with a ch2 load
    loadValid = 1'b1; loadCh = 2'd0; loadDiv = 16'd5; loadHigh = 16'd2;
    step();
    loadCh = 2'd1; loadDiv = 16'd7; loadHigh = 16'd3;
    step();
    restart = 1'b1; loadCh = 2'd2; loadDiv = 16'd3; loadHigh = 16'd1;
    step();
    chk("restart_tick", 32'(tick), 32'd7);
    restart = 1'b0; loadValid = 1'b0;
    #1 chk("ready_ch2_pending", 32'(loadReady), 32'd0);
    for (int i = 0; i < 5; i++) step();
    step();
    chk("applied_ch2", 32'(applied), 32'd4);
    step(); step();

    // Asynchronous reset mid-period
    #2 rst = 1'b1;
    #1;
    chk("arst_smallClk", 32'(smallClk), 32'd0);
    chk("arst_tick", 32'(tick), 32'd0);
    chk("arst_applied", 32'(applied), 32'd0);
    loadCh = 2'd2;
    #1 chk("arst_ready", 32'(loadReady), 32'd1);
    @(posedge bigClk); #1;
    rst = 1'b0;
    model_reset();
    step();
    chk("post_rst_tick", 32'(tick), 32'd7);

    // high=0 on ch0 (div 3), high>=div on ch1 (div 2)
    loadValid = 1'b1; loadCh = 2'd0; loadDiv = 16'd3; loadHigh = 16'd0;
    step();
    loadCh = 2'd1; loadDiv = 16'd2; loadHigh = 16'd5;
    step();
    loadValid = 1'b0;
    for (int i = 0; i < 10; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_clk_divider.md
# multi_clk_divider

Parametrised bank of independent programmable clock dividers for the ECG datapath. Each channel derives a duty-cycle-controlled `smallClk` and a one-cycle `tick` strobe (for sample-rate enables) from `bigClk`. Divisor and high-time are reprogrammable at run time through a valid/ready load port, with glitch-free update at period boundaries. A `restart` input phase-aligns all channels.

## Interface
- `NUM_CH`, default 2: number of divider channels, 1..16.
- `CNT_W`, default 16: counter, divisor and high-time width.
- `DEFAULT_DIV`, default 6: reset divisor, ≥2; reset high-time is `DEFAULT_DIV/2`.
- `CH_W`, default `max(1,$clog2(NUM_CH))`: channel-index width (derived).
- `bigClk` in 1: single clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: global count enable.
- `restart` in 1: synchronous phase-align pulse for all channels.
- `loadValid` in 1: load request.
- `loadReady` out 1: load accepted when `loadValid & loadReady`.
- `loadCh` in CH_W: target channel.
- `loadDiv` in CNT_W: new period in `bigClk` cycles.
- `loadHigh` in CNT_W: new high-time in `bigClk` cycles.
- `loadErr` out 1: one-cycle pulse on an accepted load with `loadDiv<2`.
- `smallClk` out NUM_CH: divided clock per channel (registered).
- `tick` out NUM_CH: one-cycle pulse per channel at period start (registered).
- `applied` out NUM_CH: one-cycle pulse when a pending load takes effect.

## Operation
- Per channel, active regs `div`, `high`, `cnt`; shadow regs `sDiv`, `sHigh`; flag `pending`.
- Reset: `cnt=DEFAULT_DIV-1`, `div=DEFAULT_DIV`, `high=DEFAULT_DIV/2`, `pending=0`. Outputs `smallClk`, `tick`, `applied`, `loadErr` are all 0.
- Enabled edge (`en=1`, no `restart`): `cnt_n = (cnt==div-1) ? 0 : cnt+1`. Then `cnt<=cnt_n`, `smallClk<=(cnt_n<high)`, `tick<=(cnt_n==0)`.
- `en=0`: `cnt` and `smallClk` hold; `tick` and `applied` are 0; pending loads wait.
- Boundary (enabled edge with `cnt_n==0`) and `pending=1`: `div<=sDiv`, `high<=sHigh`, `pending<=0`, `applied<=1`. `smallClk<=(0<sHigh)` uses the new high-time.
- `loadReady = (loadCh<NUM_CH) & !pending[loadCh]`. An out-of-range channel is never accepted.
- Accept with `loadDiv≥2`: `sDiv`, `sHigh` captured; `pending<=1`.
- Accept with `loadDiv<2`: `loadErr` pulses the next cycle; shadow regs and `pending` are unchanged.
- Accept coinciding with a boundary on the same channel: the old pending value, if any, applies at this edge. The new load applies at the following boundary, never the same edge.
- `high=0` gives constant-low `smallClk`. `high≥div` gives constant-high `smallClk`. `tick` is unaffected in both cases.
- `restart=1` (overrides `en`): every channel applies its pending load immediately if any (`applied` pulses), then sets `cnt<=0`, `tick<=1`, `smallClk<=(0<high_eff)`.
- A load accepted on the same edge as `restart` is not applied by that `restart`.

## Timing
- Load latency: from acceptance to `applied`, at most the remainder of the current period plus 1 cycle, while `en=1`.
- `tick` period equals `div`. `smallClk` high for exactly `min(high,div)` cycles per period.
- First enabled edge after reset gives `tick=1` and `smallClk=1` (`cnt` wraps to 0).
- `rst` mid-operation immediately clears outputs and returns all registers to reset values, discarding pending loads.
- No combinational path from inputs to outputs except `loadReady` (from `loadCh` and `pending`).

## Structure
- Package `clk_div_pkg`: `CNT_W` default, `clog2`-based `CH_W` helper, typedef struct `div_cfg_t {div, high}`, constant `DIV_MIN=2`.
- Sub-module `clk_div_channel`: one counter, its shadow registers and its output flops.
- Top generates `NUM_CH` instances and decodes the load port and `loadReady`.

## Test plan
- Reset, `en=1`, defaults (div 6): `tick` every 6 cycles starting at first edge; `smallClk` 1,1,1,0,0,0 repeating on both channels.
- Load ch1 div=4 high=1 mid-period: `applied[1]` at ch1's next wrap; thereafter `smallClk[1]` pattern 1,0,0,0; ch0 undisturbed.
- Second load to ch1 while pending: `loadReady=0` until `applied[1]`.
- Load with `loadDiv=1`: `loadErr` pulse one cycle later; output pattern unchanged.
- Out-of-range `loadCh` (NUM_CH=3, `loadCh=3`): `loadReady=0`.
- `en` low for 5 cycles mid-period: outputs freeze, no `tick`; resume continues from the frozen count.
- Ch0 div=5, ch1 div=7, then `restart`: both `tick` on the same cycle; pending loads applied.
- `rst` asserted asynchronously mid-period: outputs 0 immediately.
